// File: rtl/alu_seq_if.sv
// Bundles the command channel, ALU request/result port and debug/status signals of alu_seq.
// ALU_SEQ_FLAGS_EN adds the flag_z/flag_n status signals.
interface alu_seq_if #(
    parameter int unsigned DW = 8
);
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_ld;
    logic [2:0]    cmd_op;
    logic [2:0]    cmd_srca;
    logic [2:0]    cmd_srcb;
    logic [2:0]    cmd_dst;
    logic [DW-1:0] cmd_imm;
    logic [DW-1:0] alu_a;
    logic [DW-1:0] alu_b;
    logic [2:0]    alu_sel;
    logic [2:0]    alu_addr;
    logic          alu_en;
    logic [DW-1:0] alu_out;
    logic [2:0]    alu_out_addr;
    logic [2:0]    rd_addr;
    logic [DW-1:0] rd_data;
    logic          done;
    logic          err;
`ifdef ALU_SEQ_FLAGS_EN
    logic          flag_z;
    logic          flag_n;
`endif

    // Sequencer view
    modport slave (
        input  cmd_valid, cmd_ld, cmd_op, cmd_srca, cmd_srcb, cmd_dst, cmd_imm,
        input  alu_out, alu_out_addr, rd_addr,
`ifdef ALU_SEQ_FLAGS_EN
        output flag_z, flag_n,
`endif
        output cmd_ready, alu_a, alu_b, alu_sel, alu_addr, alu_en, rd_data, done, err
    );

    // Command source / ALU / debug view
    modport master (
        output cmd_valid, cmd_ld, cmd_op, cmd_srca, cmd_srcb, cmd_dst, cmd_imm,
        output alu_out, alu_out_addr, rd_addr,
`ifdef ALU_SEQ_FLAGS_EN
        input  flag_z, flag_n,
`endif
        input  cmd_ready, alu_a, alu_b, alu_sel, alu_addr, alu_en, rd_data, done, err
    );
endinterface

// File: rtl/alu_seq.sv
// ALU command sequencer with 8-entry register file: loads, operand issue, result write-back.
// Optional ALU_SEQ_FLAGS_EN adds registered zero/negative flags of the last written value.
module alu_seq #(
    parameter int unsigned DW = 8
) (
    input  logic     clk,
    input  logic     rst_n,
    alu_seq_if.slave bus
);
    typedef enum logic [1:0] {StIdle, StIssue, StCapture} state_e;

    state_e                 r_state;
    state_e                 w_state_d;
    logic [7:0][DW-1:0]     r_rf;
    logic [2:0]             r_dst;
    logic [DW-1:0]          r_alu_a;
    logic [DW-1:0]          r_alu_b;
    logic [2:0]             r_alu_sel;
    logic [2:0]             r_alu_addr;
    logic                   r_alu_en;
    logic                   r_done;
    logic                   r_err;
    logic                   w_accept_op;
    logic                   w_we;
    logic [2:0]             w_waddr;
    logic [DW-1:0]          w_wdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    // Loads write at the accept edge; ops write back from CAPTURE.
    always_comb begin
        w_state_d   = r_state;
        w_accept_op = 1'b0;
        w_we        = 1'b0;
        w_waddr     = bus.cmd_dst;
        w_wdata     = bus.cmd_imm;
        unique case (r_state)
            StIdle: begin
                if (bus.cmd_valid) begin
                    if (bus.cmd_ld) begin
                        w_we = 1'b1;
                    end else begin
                        w_accept_op = 1'b1;
                        w_state_d   = StIssue;
                    end
                end
            end
            StIssue: begin
                w_state_d = StCapture;
            end
            StCapture: begin
                w_we      = 1'b1;
                w_waddr   = r_dst;
                w_wdata   = bus.alu_out;
                w_state_d = StIdle;
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rf       <= '0;
            r_dst      <= '0;
            r_alu_a    <= '0;
            r_alu_b    <= '0;
            r_alu_sel  <= '0;
            r_alu_addr <= '0;
            r_alu_en   <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_alu_en <= w_accept_op;
            r_done   <= w_we;
            if (w_we) begin
                r_rf[w_waddr] <= w_wdata;
            end
            // Operands captured at accept, so src == dst sees the pre-op value.
            if (w_accept_op) begin
                r_alu_a    <= r_rf[bus.cmd_srca];
                r_alu_b    <= r_rf[bus.cmd_srcb];
                r_alu_sel  <= bus.cmd_op;
                r_alu_addr <= bus.cmd_dst;
                r_dst      <= bus.cmd_dst;
            end
            if ((r_state == StCapture) && (bus.alu_out_addr != r_dst)) begin
                r_err <= 1'b1;
            end
        end
    end

`ifdef ALU_SEQ_FLAGS_EN
    logic r_flag_z;
    logic r_flag_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_flag_z <= 1'b0;
            r_flag_n <= 1'b0;
        end else if (w_we) begin
            r_flag_z <= (w_wdata == '0);
            r_flag_n <= w_wdata[DW-1];
        end
    end

    assign bus.flag_z = r_flag_z;
    assign bus.flag_n = r_flag_n;
`endif

    assign bus.cmd_ready = (r_state == StIdle);
    assign bus.alu_a     = r_alu_a;
    assign bus.alu_b     = r_alu_b;
    assign bus.alu_sel   = r_alu_sel;
    assign bus.alu_addr  = r_alu_addr;
    assign bus.alu_en    = r_alu_en;
    assign bus.rd_data   = r_rf[bus.rd_addr];
    assign bus.done      = r_done;
    assign bus.err       = r_err;
endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq with a small registered ALU model.
// Flag checks are included when ALU_SEQ_FLAGS_EN is defined.
module tb_alu_seq;
    logic clk;
    logic rst_n;
    logic bad_tag;
    int   total;
    int   bad;

    alu_seq_if #(.DW(8)) bus ();

    alu_seq #(.DW(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // ALU reference: 0 avg, 1 half-difference, 2 and, 3 or, else xor
    function automatic logic [7:0] alu_f(input logic [2:0] sel, input logic [7:0] a,
                                         input logic [7:0] b);
        logic [8:0] s;
        logic [7:0] d;
        s = {1'b0, a} + {1'b0, b};
        d = a - b;
        case (sel)
            3'd0:    alu_f = s[8:1];
            3'd1:    alu_f = d >> 1;
            3'd2:    alu_f = a & b;
            3'd3:    alu_f = a | b;
            default: alu_f = a ^ b;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (bus.alu_en) begin
            bus.alu_out      <= alu_f(bus.alu_sel, bus.alu_a, bus.alu_b);
            bus.alu_out_addr <= bad_tag ? 3'd7 : bus.alu_addr;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input string tag, input logic [2:0] a, input logic [7:0] exp);
        bus.rd_addr = a;
        #1;
        check(tag, {24'd0, bus.rd_data}, {24'd0, exp});
    endtask

    task automatic do_load(input logic [2:0] d, input logic [7:0] imm);
        bus.cmd_valid = 1'b1;
        bus.cmd_ld    = 1'b1;
        bus.cmd_dst   = d;
        bus.cmd_imm   = imm;
        check("ld_ready", {31'd0, bus.cmd_ready}, 32'd1);
        tick();
        bus.cmd_valid = 1'b0;
        check("ld_done", {31'd0, bus.done}, 32'd1);
        rd("ld_rd", d, imm);
    endtask

    task automatic do_op(input logic [2:0] op, input logic [2:0] sa, input logic [2:0] sb,
                         input logic [2:0] d, input logic [7:0] ea, input logic [7:0] eb,
                         input logic [7:0] er);
        bus.cmd_valid = 1'b1;
        bus.cmd_ld    = 1'b0;
        bus.cmd_op    = op;
        bus.cmd_srca  = sa;
        bus.cmd_srcb  = sb;
        bus.cmd_dst   = d;
        check("op_ready_idle", {31'd0, bus.cmd_ready}, 32'd1);
        tick();
        bus.cmd_valid = 1'b0;
        check("op_en_issue", {31'd0, bus.alu_en}, 32'd1);
        check("op_alu_a", {24'd0, bus.alu_a}, {24'd0, ea});
        check("op_alu_b", {24'd0, bus.alu_b}, {24'd0, eb});
        check("op_alu_sel", {29'd0, bus.alu_sel}, {29'd0, op});
        check("op_alu_addr", {29'd0, bus.alu_addr}, {29'd0, d});
        check("op_ready_issue", {31'd0, bus.cmd_ready}, 32'd0);
        check("op_done_issue", {31'd0, bus.done}, 32'd0);
        tick();
        check("op_en_capture", {31'd0, bus.alu_en}, 32'd0);
        check("op_ready_capture", {31'd0, bus.cmd_ready}, 32'd0);
        check("op_done_capture", {31'd0, bus.done}, 32'd0);
        tick();
        check("op_done_wb", {31'd0, bus.done}, 32'd1);
        check("op_ready_wb", {31'd0, bus.cmd_ready}, 32'd1);
        rd("op_result", d, er);
        tick();
        check("op_done_once", {31'd0, bus.done}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        total         = 0;
        bad           = 0;
        bad_tag       = 1'b0;
        rst_n         = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_ld    = 1'b0;
        bus.cmd_op    = 3'd0;
        bus.cmd_srca  = 3'd0;
        bus.cmd_srcb  = 3'd0;
        bus.cmd_dst   = 3'd0;
        bus.cmd_imm   = 8'd0;
        bus.rd_addr   = 3'd0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Reset state
        check("rst_ready", {31'd0, bus.cmd_ready}, 32'd1);
        check("rst_en", {31'd0, bus.alu_en}, 32'd0);
        check("rst_err", {31'd0, bus.err}, 32'd0);
        check("rst_done", {31'd0, bus.done}, 32'd0);
        for (int i = 0; i < 8; i++) rd("rst_rf", 3'(i), 8'h00);

        // Back-to-back loads, then average op
        do_load(3'd1, 8'h10);
        do_load(3'd2, 8'h20);
        tick();
        do_op(3'd0, 3'd1, 3'd2, 3'd3, 8'h10, 8'h20, 8'h18);

        // Source == destination, cmd_valid held through the op
        do_load(3'd4, 8'hF0);
        do_load(3'd5, 8'h3C);
        bus.cmd_valid = 1'b1;
        bus.cmd_ld    = 1'b0;
        bus.cmd_op    = 3'd2;
        bus.cmd_srca  = 3'd4;
        bus.cmd_srcb  = 3'd5;
        bus.cmd_dst   = 3'd4;
        tick();
        check("hold_alu_a", {24'd0, bus.alu_a}, 32'hF0);
        bus.cmd_ld  = 1'b1;
        bus.cmd_dst = 3'd0;
        bus.cmd_imm = 8'h11;
        check("hold_ready_issue", {31'd0, bus.cmd_ready}, 32'd0);
        tick();
        check("hold_ready_capture", {31'd0, bus.cmd_ready}, 32'd0);
        rd("hold_r0_not_taken", 3'd0, 8'h00);
        tick();
        check("hold_ready_back", {31'd0, bus.cmd_ready}, 32'd1);
        check("hold_done_op", {31'd0, bus.done}, 32'd1);
        rd("hold_r4", 3'd4, 8'h30);
        rd("hold_r0_still", 3'd0, 8'h00);
        tick();
        bus.cmd_valid = 1'b0;
        check("hold_done_ld", {31'd0, bus.done}, 32'd1);
        rd("hold_r0_loaded", 3'd0, 8'h11);
        tick();

        // Reset during ISSUE aborts the op
        do_load(3'd1, 8'h20);
        do_load(3'd2, 8'h10);
        bus.cmd_valid = 1'b1;
        bus.cmd_ld    = 1'b0;
        bus.cmd_op    = 3'd1;
        bus.cmd_srca  = 3'd1;
        bus.cmd_srcb  = 3'd2;
        bus.cmd_dst   = 3'd6;
        tick();
        bus.cmd_valid = 1'b0;
        check("abort_en", {31'd0, bus.alu_en}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("abort_en_rst", {31'd0, bus.alu_en}, 32'd0);
        check("abort_ready_rst", {31'd0, bus.cmd_ready}, 32'd1);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check("abort_done", {31'd0, bus.done}, 32'd0);
        rd("abort_r6", 3'd6, 8'h00);
        tick();
        check("abort_done2", {31'd0, bus.done}, 32'd0);
        do_load(3'd1, 8'h20);
        do_load(3'd2, 8'h10);
        tick();
        do_op(3'd1, 3'd1, 3'd2, 3'd6, 8'h20, 8'h10, 8'h08);

        // Tag mismatch: sticky err, write still lands on dst
        do_load(3'd7, 8'h5A);
        bad_tag = 1'b1;
        do_op(3'd3, 3'd1, 3'd2, 3'd3, 8'h20, 8'h10, 8'h30);
        check("err_set", {31'd0, bus.err}, 32'd1);
        rd("err_r7", 3'd7, 8'h5A);
        bad_tag = 1'b0;
        do_op(3'd0, 3'd1, 3'd2, 3'd5, 8'h20, 8'h10, 8'h18);
        check("err_sticky", {31'd0, bus.err}, 32'd1);
        rd("err_r7_after", 3'd7, 8'h5A);

`ifdef ALU_SEQ_FLAGS_EN
        do_load(3'd0, 8'h00);
        check("flag_z_zero", {31'd0, bus.flag_z}, 32'd1);
        check("flag_n_zero", {31'd0, bus.flag_n}, 32'd0);
        do_load(3'd1, 8'h80);
        check("flag_z_neg", {31'd0, bus.flag_z}, 32'd0);
        check("flag_n_neg", {31'd0, bus.flag_n}, 32'd1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/alu_seq.md
# alu_seq

Command sequencer and write-back unit for the ALU. It accepts operation commands over a valid/ready handshake and holds an 8-entry x 8-bit register file. It fetches operands, drives the ALU request port (`a`, `b`, `sel`, `addr`, `alu_en`), captures the registered result (`out`, `out_addr`) one cycle later, and writes it back. It sits between the command source and the ALU and is the initiator side of the ALU interface.

## Interface
- `DW`, 8: data width; must match ALU operand width.
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: high in IDLE only; combinational from state.
- `cmd_ld` in 1: 1 = load `cmd_imm` into `cmd_dst`; 0 = ALU op.
- `cmd_op` in 3: ALU `sel` code 0-7.
- `cmd_srca`, `cmd_srcb`, `cmd_dst` in 3 each: register indices.
- `cmd_imm` in DW: load immediate.
- `alu_a`, `alu_b` out DW: registered operands.
- `alu_sel` out 3, `alu_addr` out 3: registered op code and destination tag.
- `alu_en` out 1: registered; high exactly during ISSUE.
- `alu_out` in DW, `alu_out_addr` in 3: ALU registered result and tag.
- `rd_addr` in 3, `rd_data` out DW: combinational debug read of the register file.
- `done` out 1: one-cycle pulse after every register-file write.
- `err` out 1: sticky tag-mismatch flag.
- `flag_z`, `flag_n` out 1: present only with `ALU_SEQ_FLAGS_EN`.

## Operation
- States: IDLE, ISSUE, CAPTURE.
- IDLE, accepted load (`cmd_valid && cmd_ld`): `rf[cmd_dst] <= cmd_imm` at the accept edge. `done` is high the next cycle. State stays IDLE.
- IDLE, accepted op (`cmd_valid && !cmd_ld`), at the accept edge:
  - `alu_a <= rf[cmd_srca]`, `alu_b <= rf[cmd_srcb]`, `alu_sel <= cmd_op`, `alu_addr <= cmd_dst`, `alu_en <= 1`.
  - The internal `dst_q` latches `cmd_dst`.
  - Next state is ISSUE.
- ISSUE: the ALU samples its inputs at the closing edge. `alu_en <= 0`. Next state is CAPTURE.
- CAPTURE, at the closing edge:
  - `rf[dst_q] <= alu_out`; `done <= 1`.
  - If `alu_out_addr != dst_q`, `err <= 1`. The write still targets `dst_q`.
  - Next state is IDLE.
- Operands are read at accept. A source equal to the destination uses the pre-op value.
- `cmd_ready` is low in ISSUE and CAPTURE. Commands presented then are held off; no command is dropped or queued.
- `err` clears only on reset.
- `alu_a`, `alu_b`, `alu_sel`, `alu_addr` hold their last values outside ISSUE.
- Any result width or sign rules are the ALU's own. `alu_seq` stores `alu_out` verbatim.

## Timing
- Reset values (async assert, clocked release):
  - state IDLE, all 8 `rf` entries 0x00, `dst_q` 0.
  - `alu_a`, `alu_b`, `alu_sel`, `alu_addr` all 0; `alu_en` 0.
  - `done` 0, `err` 0, `flag_z` 0, `flag_n` 0.
- ALU op, accepted at edge t0:
  - `alu_en` is high during cycle t0..t0+1.
  - The ALU result is valid during cycle t0+1..t0+2.
  - `rf` is written at edge t0+2.
  - `done` is high during t0+2..t0+3, and `cmd_ready` is high again in the same cycle.
  - Op throughput is 1 per 3 cycles; the next accept is at t0+3 at the earliest.
- Load: written at the accept edge, `done` high the following cycle, 1 load per cycle sustained.
- Reset mid-operation (ISSUE or CAPTURE): the op is aborted and no write-back occurs.
- `rd_data` reflects a write on the cycle after the write edge.

## Configuration
- `ALU_SEQ_FLAGS_EN` defined: adds ports `flag_z` and `flag_n`. Both are registered and updated on every register-file write, load or op:
  - `flag_z = (written data == 0)`.
  - `flag_n = written data[DW-1]`.
- Undefined: the flag ports and their registers are absent. All other behaviour is identical.

## Test plan
- Reset then `rd_addr` 0-7 -> `rd_data` = 0x00 for every entry; `cmd_ready` = 1, `alu_en` = 0, `err` = 0.
- Load r1 = 0x10 and r2 = 0x20 on back-to-back cycles; then op 0, srca 1, srcb 2, dst 3 -> `alu_en` high for one cycle with `alu_a` = 0x10, `alu_b` = 0x20; r3 = 0x18 written at accept+2; exactly one `done` for the op.
- Load r4 = 0xF0, r5 = 0x3C; op 2, dst 4, srca 4, srcb 5 -> r4 = 0x30. Hold `cmd_valid` through the op -> `cmd_ready` low for exactly 2 cycles, and the next command is accepted at accept+3.
- Assert `rst_n` low during ISSUE of op 1 (r1 = 0x20, r2 = 0x10, dst 6) -> r6 stays 0x00, no `done`. After release, rerun the op -> r6 = 0x08.
- ALU model returns `alu_out_addr` = 7 for dst 3 -> `err` = 1 and stays 1 across later good ops; the value is written to r3, and r7 is unchanged.
- With `ALU_SEQ_FLAGS_EN`: load r0 = 0x00 -> `flag_z` = 1, `flag_n` = 0. Then load r1 = 0x80 -> `flag_z` = 0, `flag_n` = 1.
